// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the shared-bus arbiter: limits, state encodings and
// small helpers used by the arbiter top and its round-robin picker.
package bus_arbiter_pkg;

   localparam int unsigned BUS_MAX_MASTERS = 8;
   localparam int unsigned BUS_WD_WIDTH    = 16;
   localparam int unsigned BUS_IDX_WIDTH   = 3;

   localparam logic [1:0] BUS_ARB_IDLE       = 2'd0;
   localparam logic [1:0] BUS_ARB_GRANTED    = 2'd1;
   localparam logic [1:0] BUS_ARB_TURNAROUND = 2'd2;

   typedef logic [BUS_IDX_WIDTH-1:0] bus_idx_t;
   typedef logic [BUS_WD_WIDTH-1:0]  bus_wd_t;

   function automatic int unsigned bus_wrap(input int unsigned value, input int unsigned modulus);
      return value % modulus;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester scanning circularly from
// last_owner+1, as a one-hot vector plus its encoded index.
module bus_arbiter_rr_pick
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned MASTERS = 4
) (
   input  logic [MASTERS-1:0] i_req,
   input  bus_idx_t           i_last_owner,
   output logic               o_valid,
   output logic [MASTERS-1:0] o_pick,
   output bus_idx_t           o_pick_idx
);

   int unsigned        w_start;
   int unsigned        w_off;
   int unsigned        w_idx;
   logic               w_found;
   logic [MASTERS-1:0] w_rot;

   always_comb begin
      w_start = bus_wrap(32'(i_last_owner) + 32'd1, MASTERS);

      // Rotate so that bit 0 is the highest-priority master this round.
      w_rot = '0;
      for (int unsigned i = 0; i < MASTERS; i++) begin
         for (int unsigned k = 0; k < MASTERS; k++) begin
            if (k == bus_wrap(w_start + i, MASTERS)) begin
               w_rot[i] = i_req[k];
            end
         end
      end

      w_found = 1'b0;
      w_off   = 0;
      for (int unsigned i = 0; i < MASTERS; i++) begin
         if (!w_found && w_rot[i]) begin
            w_found = 1'b1;
            w_off   = i;
         end
      end

      w_idx      = bus_wrap(w_start + w_off, MASTERS);
      o_valid    = w_found;
      o_pick_idx = BUS_IDX_WIDTH'(w_idx);
      o_pick     = '0;
      for (int unsigned k = 0; k < MASTERS; k++) begin
         o_pick[k] = w_found && (k == w_idx);
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with a turnaround cycle between owners and a
// watchdog that forces completion of unacknowledged transfers.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned MASTERS        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [MASTERS-1:0] bus_req,
   output logic [MASTERS-1:0] bus_grant,
   input  logic               rd_bus,
   input  logic               wr_bus,
   input  logic               fc_bus,
   output logic               fc_force,
   output logic               timeout_err,
   output logic [2:0]         timeout_master,
   output logic               bus_busy
);

   localparam bus_wd_t LP_WD_LIMIT = BUS_WD_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [1:0]               r_state;
   bus_idx_t                 r_owner;
   bus_idx_t                 r_last_owner;
   bus_wd_t                  r_wd;
   logic [MASTERS-1:0]       r_grant;
   logic                     r_busy;
   logic                     r_fc_force;
   logic                     r_timeout_err;
   bus_idx_t                 r_timeout_master;

   logic [BUS_MAX_MASTERS-1:0] w_req_ext;
   logic                       w_owner_req;
   logic                       w_stall;
   logic                       w_limit;
   logic                       w_valid;
   logic [MASTERS-1:0]         w_pick;
   bus_idx_t                   w_pick_idx;

   bus_arbiter_rr_pick #(
      .MASTERS(MASTERS)
   ) u_rr_pick (
      .i_req        (bus_req),
      .i_last_owner (r_last_owner),
      .o_valid      (w_valid),
      .o_pick       (w_pick),
      .o_pick_idx   (w_pick_idx)
   );

   always_comb begin
      w_req_ext = '0;
      for (int unsigned i = 0; i < MASTERS; i++) begin
         w_req_ext[i] = bus_req[i];
      end
      w_owner_req = w_req_ext[r_owner];
      // Owner's request is part of the condition so that leaving GRANTED clears wd.
      w_stall = (r_state == BUS_ARB_GRANTED) && w_owner_req && (rd_bus || wr_bus) && !fc_bus;
      w_limit = (r_wd == LP_WD_LIMIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= BUS_ARB_IDLE;
         r_owner      <= '0;
         r_last_owner <= BUS_IDX_WIDTH'(MASTERS - 1);
         r_grant      <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            BUS_ARB_IDLE: begin
               if (w_valid) begin
                  r_grant      <= w_pick;
                  r_busy       <= 1'b1;
                  r_owner      <= w_pick_idx;
                  r_last_owner <= w_pick_idx;
                  r_state      <= BUS_ARB_GRANTED;
               end
            end
            BUS_ARB_GRANTED: begin
               if (!w_owner_req) begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_state <= BUS_ARB_TURNAROUND;
               end
            end
            BUS_ARB_TURNAROUND: begin
               r_state <= BUS_ARB_IDLE;
            end
            default: begin
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= BUS_ARB_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wd             <= '0;
         r_fc_force       <= 1'b0;
         r_timeout_err    <= 1'b0;
         r_timeout_master <= '0;
      end else begin
         r_fc_force    <= 1'b0;
         r_timeout_err <= 1'b0;
         if (w_stall && w_limit) begin
            r_wd             <= '0;
            r_fc_force       <= 1'b1;
            r_timeout_err    <= 1'b1;
            r_timeout_master <= r_owner;
         end else if (w_stall) begin
            r_wd <= r_wd + 16'd1;
         end else begin
            r_wd <= '0;
         end
      end
   end

   assign bus_grant      = r_grant;
   assign bus_busy       = r_busy;
   assign fc_force       = r_fc_force;
   assign timeout_err    = r_timeout_err;
   assign timeout_master = r_timeout_master;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a behavioural ownership/stall model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_bus_arbiter;

   localparam int M = 4;
   localparam int T = 5;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic [3:0] bus_req = 4'b0000;
   logic       rd_bus  = 1'b0;
   logic       wr_bus  = 1'b0;
   logic       fc_bus  = 1'b0;
   logic [3:0] bus_grant;
   logic       fc_force;
   logic       timeout_err;
   logic [2:0] timeout_master;
   logic       bus_busy;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   bus_arbiter #(
      .MASTERS        (M),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus_req        (bus_req),
      .bus_grant      (bus_grant),
      .rd_bus         (rd_bus),
      .wr_bus         (wr_bus),
      .fc_bus         (fc_bus),
      .fc_force       (fc_force),
      .timeout_err    (timeout_err),
      .timeout_master (timeout_master),
      .bus_busy       (bus_busy)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who owns the bus, how many idle cycles must still pass, stall length.
   int m_owner = -1;
   int m_last  = M - 1;
   int m_cool  = 0;
   int m_cnt   = 0;
   int m_tm    = 0;
   bit m_force = 1'b0;

   always @(posedge clk or negedge rst) begin
      bit stall;
      if (!rst) begin
         m_owner = -1;
         m_last  = M - 1;
         m_cool  = 0;
         m_cnt   = 0;
         m_tm    = 0;
         m_force = 1'b0;
      end else begin
         stall = (m_owner >= 0) && bus_req[m_owner] && (rd_bus || wr_bus) && !fc_bus;
         m_force = 1'b0;
         if (stall) begin
            m_cnt++;
            if (m_cnt == T) begin
               m_force = 1'b1;
               m_tm    = m_owner;
               m_cnt   = 0;
            end
         end else begin
            m_cnt = 0;
         end
         if (m_owner >= 0) begin
            if (!bus_req[m_owner]) begin
               m_owner = -1;
               m_cool  = 1;
            end
         end else if (m_cool > 0) begin
            m_cool--;
         end else begin
            for (int i = 1; i <= M; i++) begin
               int c;
               c = (m_last + i) % M;
               if (bus_req[c]) begin
                  m_owner = c;
                  m_last  = c;
                  break;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] exp_g;
      if (chk_en) begin
         exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
         check("model_grant", {4'h0, bus_grant}, {4'h0, exp_g});
         check("model_busy", {7'h0, bus_busy}, {7'h0, |exp_g});
         check("model_fc_force", {7'h0, fc_force}, {7'h0, m_force});
         check("model_timeout_err", {7'h0, timeout_err}, {7'h0, m_force});
         check("model_timeout_master", {5'h0, timeout_master}, 8'(m_tm));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_grant(input string name, input logic [3:0] exp, input int budget);
      int k;
      k = 0;
      while (bus_grant == 4'b0000 && k < budget) begin
         tick();
         k++;
      end
      check(name, {4'h0, bus_grant}, {4'h0, exp});
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int order [3] = '{2, 3, 0};
      int cur;

      // Reset with every master requesting.
      bus_req = 4'b1111;
      ticks(2);
      check("reset_grant", {4'h0, bus_grant}, 8'h00);
      check("reset_busy", {7'h0, bus_busy}, 8'h00);
      check("reset_fc_force", {7'h0, fc_force}, 8'h00);
      check("reset_tmaster", {5'h0, timeout_master}, 8'h00);
      rst    = 1'b1;
      chk_en = 1'b1;
      tick();
      check("first_grant", {4'h0, bus_grant}, 8'h01);
      check("first_busy", {7'h0, bus_busy}, 8'h01);

      // Master 0 holds three cycles, then drops.
      tick();
      check("hold0_c2", {4'h0, bus_grant}, 8'h01);
      tick();
      check("hold0_c3", {4'h0, bus_grant}, 8'h01);
      bus_req = 4'b1110;
      tick();
      check("release_gap1", {4'h0, bus_grant}, 8'h00);
      tick();
      check("turnaround_gap2", {4'h0, bus_grant}, 8'h00);
      tick();
      check("next_owner1", {4'h0, bus_grant}, 8'h02);

      // Finish the rotation 1 -> 2 -> 3 -> 0.
      cur = 1;
      foreach (order[i]) begin
         bus_req = 4'b1111 & ~(4'b0001 << cur);
         ticks(3);
         check("rotation", {4'h0, bus_grant}, 8'(4'b0001 << order[i]));
         cur = order[i];
      end
      bus_req = 4'b0000;
      ticks(3);

      // No preemption while master 2 owns.
      bus_req = 4'b0100;
      wait_grant("own2", 4'b0100, 4);
      bus_req = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_preempt", {4'h0, bus_grant}, 8'h04);
      end
      bus_req = 4'b0001;
      ticks(3);
      check("after2_to0", {4'h0, bus_grant}, 8'h01);
      bus_req = 4'b0000;
      ticks(3);

      // Watchdog: owner 1 stalls a read.
      bus_req = 4'b0010;
      wait_grant("own1", 4'b0010, 4);
      rd_bus = 1'b1;
      for (int i = 0; i < T - 1; i++) begin
         tick();
         check("wd_pre_fire", {7'h0, fc_force}, 8'h00);
      end
      tick();
      check("wd_fc_force", {7'h0, fc_force}, 8'h01);
      check("wd_timeout_err", {7'h0, timeout_err}, 8'h01);
      check("wd_tmaster", {5'h0, timeout_master}, 8'h01);
      check("wd_grant_kept", {4'h0, bus_grant}, 8'h02);
      tick();
      check("wd_pulse_end", {7'h0, fc_force}, 8'h00);
      check("wd_tmaster_hold", {5'h0, timeout_master}, 8'h01);
      rd_bus = 1'b0;
      tick();

      // Acknowledge at count T-1 wins; later stall restarts the full count.
      wr_bus = 1'b1;
      ticks(T - 1);
      fc_bus = 1'b1;
      tick();
      check("fc_wins", {7'h0, fc_force}, 8'h00);
      fc_bus = 1'b0;
      for (int i = 0; i < T - 1; i++) begin
         tick();
         check("restart_pre_fire", {7'h0, timeout_err}, 8'h00);
      end
      tick();
      check("restart_fire", {7'h0, fc_force}, 8'h01);
      wr_bus = 1'b0;
      bus_req = 4'b0000;
      ticks(3);

      // Asynchronous reset during a granted write.
      bus_req = 4'b1111;
      wait_grant("own2_before_rst", 4'b0100, 4);
      wr_bus = 1'b1;
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_grant", {4'h0, bus_grant}, 8'h00);
      check("async_rst_busy", {7'h0, bus_busy}, 8'h00);
      check("async_rst_tmaster", {5'h0, timeout_master}, 8'h00);
      ticks(2);
      rst    = 1'b1;
      wr_bus = 1'b0;
      tick();
      check("post_rst_prio0", {4'h0, bus_grant}, 8'h01);

      bus_req = 4'b0000;
      ticks(3);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
